axis_lane_alu: RTL and testbench
================================

Name: axis_lane_alu

Overview:
- AXI4-Stream processing stage for the reconfigurable partition. Sits between the TXD (ingress) and RXD (egress) stream ports.
- Splits each beat into independent lanes and applies a per-packet-selectable operation (pass, add, subtract, xor) with a broadcast operand.
- Unlike a fixed-constant adder, it has full backpressure: a registered output plus a one-entry skid buffer, so input tready never depends combinationally on output tready.
- Provides packet and beat statistics counters.

Parameters:
- DATA_W, 512, stream data width in bits; must be a multiple of LANE_W.
- LANE_W, 32, lane width; arithmetic is isolated per lane, with no carry or borrow between lanes.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk50mhz_0  in  1  sole clock; all logic is rising-edge.
- peripheral_aresetn_0  in  1  asynchronous active-low reset.
- AXI_STR_TXD_0_tdata  in  DATA_W  ingress data.
- AXI_STR_TXD_0_tlast  in  1  ingress end of packet.
- AXI_STR_TXD_0_tvalid  in  1  ingress valid.
- AXI_STR_TXD_0_tready  out  1  ingress ready.
- AXI_STR_RXD_0_tdata  out  DATA_W  egress data.
- AXI_STR_RXD_0_tlast  out  1  egress end of packet.
- AXI_STR_RXD_0_tvalid  out  1  egress valid.
- AXI_STR_RXD_0_tready  in  1  egress ready.
- cfg_mode  in  2  operation: 00 pass, 01 add, 10 sub (lane minus operand), 11 xor.
- cfg_operand  in  LANE_W  operand broadcast to every lane.
- stat_pkt_count  out  CNT_W  count of completed egress packets.
- stat_beat_count  out  CNT_W  count of egress beats.
- busy  out  1  high while a packet is in progress (past first beat, before tlast) or any beat is held.

Behaviour:
- Reset is asynchronous on the falling edge of peripheral_aresetn_0 and releases synchronously to the clock. While in reset:
  - RXD tvalid=0, tlast=0, tdata=0.
  - TXD tready=0.
  - Skid buffer empty; counters=0; busy=0; latched config = mode 00, operand 0.
- First cycle after reset release: TXD tready=1.
- Accept on the ingress side occurs when TXD tvalid && TXD tready. Transfer on the egress side occurs when RXD tvalid && RXD tready.
- Per-packet config latch:
  - Start-of-packet (sop) flag is set at reset and after each accepted beat with tlast=1; it clears on any other accepted beat.
  - On an accepted beat with sop=1, cfg_mode and cfg_operand are used for that beat and latched. All later beats of the packet use the latched values.
  - A mid-packet cfg change takes effect only from the next packet.
- Lane operation: for each lane i, out[i*LANE_W +: LANE_W] = op(in lane, operand), modulo 2^LANE_W. Wrap-around is silent; lanes never interact. Computed combinationally on the ingress beat, then registered.
- Datapath:
  - Output register (OR) plus skid register (SK).
  - TXD tready = !SK_valid, driven from a register.
  - Accept while OR is empty or being transferred: the result loads into OR.
  - Accept while OR is full and stalled: the result loads into SK.
  - When OR transfers and SK is valid: SK moves to OR and SK is cleared.
- Latency: 1 cycle from accept to RXD tvalid when unstalled. Full throughput of 1 beat/cycle.
- Ordering is strictly preserved. Data, tlast and tvalid on RXD hold stable while tvalid=1 and tready=0.
- Counters:
  - stat_beat_count += 1 per egress transfer.
  - stat_pkt_count += 1 per egress transfer with tlast=1.
  - Both wrap at 2^CNT_W, update the cycle after the transfer, and are never cleared except by reset.
- Simultaneous accept and transfer with SK empty: OR reloads with the new beat and no bubble is inserted.
- Reset asserted mid-packet: the in-flight beats are discarded and sop is set. The first beat after reset starts a new packet.

Test Plan:
- DATA_W=512, LANE_W=32, mode 01, operand 32'hdeadbeef, RXD tready=1. Single beat, all lanes 32'h00000001, tlast=1.
  -> One cycle later RXD tdata has every lane = 32'hdeadbef0, tlast=1; pkt_count=1, beat_count=1.
- Lane wrap, mode 01, operand 32'h00000002. Lane0=32'hffffffff, lane1=0.
  -> lane0=32'h00000001, lane1=32'h00000002 (no carry into lane1). Mode 10, operand 1, lane0=0 -> 32'hffffffff.
- Backpressure: RXD tready=0 for 5 cycles while 4 beats are offered back-to-back.
  -> Exactly 2 beats accepted, then TXD tready=0. RXD data is stable throughout the stall. After tready=1, beats emerge in order with no loss or duplication.
- Mid-packet config change: 3-beat packet starting with mode 11, operand 32'hffffffff; switch to mode 00 after beat 1.
  -> All 3 beats are bitwise-inverted. The next packet passes through unchanged.
- Statistics: packets of 4, 1 and 2 beats with random RXD tready stalls.
  -> pkt_count=3, beat_count=7, busy=0 at end. With CNT_W=4, 17 beats -> beat_count=1.
- Reset pulse (aresetn low, asynchronous to the clock) after beat 2 of a 4-beat packet while stalled.
  -> RXD tvalid=0 immediately; counters=0. The next beat uses the current cfg_mode (treated as sop).

Source files
------------

// File: rtl/axis_lane_alu_if.sv
// rtl/axis_lane_alu_if.sv - stream handshake bundle for one direction of the lane ALU
interface axis_lane_alu_if #(
  parameter int DATA_W = 512
) ();
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_lane_alu.sv
// rtl/axis_lane_alu.sv - per-lane pass/add/sub/xor stream stage with skid buffer and stats
module axis_lane_alu #(
  parameter int DATA_W = 512,
  parameter int LANE_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk50mhz_0,
  input  logic                  peripheral_aresetn_0,
  axis_lane_alu_if.slave        AXI_STR_TXD_0,
  axis_lane_alu_if.master       AXI_STR_RXD_0,
  input  logic [1:0]            cfg_mode,
  input  logic [LANE_W-1:0]     cfg_operand,
  output logic [CNT_W-1:0]      stat_pkt_count,
  output logic [CNT_W-1:0]      stat_beat_count,
  output logic                  busy
);

  localparam int N_LANES = DATA_W / LANE_W;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_XOR  = 2'b11
  } op_t;

  logic              sop;
  op_t               mode_q;
  logic [LANE_W-1:0] operand_q;
  op_t               eff_mode;
  logic [LANE_W-1:0] eff_operand;

  logic [DATA_W-1:0] or_data;
  logic              or_last;
  logic              or_valid;
  logic [DATA_W-1:0] sk_data;
  logic              sk_last;
  logic              sk_valid;
  logic              in_ready;

  logic [DATA_W-1:0] result;
  logic [LANE_W-1:0] lane_in;
  logic [LANE_W-1:0] lane_out;

  logic accept;
  logic xfer;
  logic sk_fill;
  logic sk_drain;
  logic sk_valid_next;

  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] beat_cnt;

  assign accept   = AXI_STR_TXD_0.tvalid && in_ready;
  assign xfer     = or_valid && AXI_STR_RXD_0.tready;
  assign sk_fill  = accept && or_valid && !xfer;
  assign sk_drain = xfer && sk_valid;
  assign sk_valid_next = sk_fill || (sk_valid && !sk_drain);

  // The first beat of a packet sees the live config; later beats see the latched copy.
  assign eff_mode    = sop ? op_t'(cfg_mode) : mode_q;
  assign eff_operand = sop ? cfg_operand     : operand_q;

  always_comb begin
    result   = '0;
    lane_in  = '0;
    lane_out = '0;
    for (int i = 0; i < N_LANES; i++) begin
      lane_in = AXI_STR_TXD_0.tdata[i*LANE_W +: LANE_W];
      case (eff_mode)
        OP_ADD:  lane_out = lane_in + eff_operand;
        OP_SUB:  lane_out = lane_in - eff_operand;
        OP_XOR:  lane_out = lane_in ^ eff_operand;
        default: lane_out = lane_in;
      endcase
      result[i*LANE_W +: LANE_W] = lane_out;
    end
  end

  always_ff @(posedge clk50mhz_0 or negedge peripheral_aresetn_0) begin
    if (!peripheral_aresetn_0) begin
      sop       <= 1'b1;
      mode_q    <= OP_PASS;
      operand_q <= '0;
    end else if (accept) begin
      if (sop) begin
        mode_q    <= eff_mode;
        operand_q <= eff_operand;
      end
      sop <= AXI_STR_TXD_0.tlast;
    end
  end

  // Ready is registered from the skid occupancy, so it never looks at egress tready.
  always_ff @(posedge clk50mhz_0 or negedge peripheral_aresetn_0) begin
    if (!peripheral_aresetn_0) begin
      or_data  <= '0;
      or_last  <= 1'b0;
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      if (sk_drain) begin
        or_data <= sk_data;
        or_last <= sk_last;
      end else if (accept && (!or_valid || xfer)) begin
        or_data  <= result;
        or_last  <= AXI_STR_TXD_0.tlast;
        or_valid <= 1'b1;
      end else if (xfer) begin
        or_valid <= 1'b0;
      end
      sk_valid <= sk_valid_next;
      in_ready <= !sk_valid_next;
    end
  end

  always_ff @(posedge clk50mhz_0) begin
    if (sk_fill) begin
      sk_data <= result;
      sk_last <= AXI_STR_TXD_0.tlast;
    end
  end

  always_ff @(posedge clk50mhz_0 or negedge peripheral_aresetn_0) begin
    if (!peripheral_aresetn_0) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
      if (or_last) begin
        pkt_cnt <= pkt_cnt + CNT_W'(1);
      end
    end
  end

  assign AXI_STR_TXD_0.tready = in_ready;
  assign AXI_STR_RXD_0.tdata  = or_data;
  assign AXI_STR_RXD_0.tlast  = or_last;
  assign AXI_STR_RXD_0.tvalid = or_valid;

  assign stat_pkt_count  = pkt_cnt;
  assign stat_beat_count = beat_cnt;
  assign busy            = !sop || or_valid || sk_valid;

endmodule

// File: tb/tb_axis_lane_alu.sv
// tb/tb_axis_lane_alu.sv - randomized scoreboard bench for axis_lane_alu
module tb_axis_lane_alu;

  localparam int DW = 512;
  localparam int LW = 32;
  localparam int NL = DW / LW;

  logic clk50mhz_0 = 1'b0;
  always #5 clk50mhz_0 = ~clk50mhz_0;

  logic          peripheral_aresetn_0;
  logic [1:0]    cfg_mode;
  logic [LW-1:0] cfg_operand;
  logic [31:0]   stat_pkt_count;
  logic [31:0]   stat_beat_count;
  logic          busy;

  axis_lane_alu_if #(.DATA_W(DW)) txd ();
  axis_lane_alu_if #(.DATA_W(DW)) rxd ();

  axis_lane_alu #(.DATA_W(DW), .LANE_W(LW), .CNT_W(32)) dut (
    .clk50mhz_0           (clk50mhz_0),
    .peripheral_aresetn_0 (peripheral_aresetn_0),
    .AXI_STR_TXD_0        (txd),
    .AXI_STR_RXD_0        (rxd),
    .cfg_mode             (cfg_mode),
    .cfg_operand          (cfg_operand),
    .stat_pkt_count       (stat_pkt_count),
    .stat_beat_count      (stat_beat_count),
    .busy                 (busy)
  );

  // Narrow-counter instance used only for the counter wrap check.
  axis_lane_alu_if #(.DATA_W(64)) s_txd ();
  axis_lane_alu_if #(.DATA_W(64)) s_rxd ();
  logic [1:0]  s_mode;
  logic [31:0] s_operand;
  logic [3:0]  s_pkt;
  logic [3:0]  s_beat;
  logic        s_busy;

  axis_lane_alu #(.DATA_W(64), .LANE_W(32), .CNT_W(4)) dut_small (
    .clk50mhz_0           (clk50mhz_0),
    .peripheral_aresetn_0 (peripheral_aresetn_0),
    .AXI_STR_TXD_0        (s_txd),
    .AXI_STR_RXD_0        (s_rxd),
    .cfg_mode             (s_mode),
    .cfg_operand          (s_operand),
    .stat_pkt_count       (s_pkt),
    .stat_beat_count      (s_beat),
    .busy                 (s_busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic rand_ready = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each lane is an independent modulo-2^32 operation.
  function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] d, input logic [1:0] m,
                                            input logic [31:0] op);
    logic [DW-1:0] r;
    logic [31:0]   a;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      a = d[i*LW +: LW];
      case (m)
        2'd0:    r[i*LW +: LW] = a;
        2'd1:    r[i*LW +: LW] = a + op;
        2'd2:    r[i*LW +: LW] = a - op;
        default: r[i*LW +: LW] = a ^ op;
      endcase
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int i = 0; i < NL; i++) d[i*LW +: LW] = $urandom;
    return d;
  endfunction

  // Monitor: scoreboard pops, hold-stability and running counter checks.
  int            mon_beats;
  int            mon_pkts;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  exp_t          got;

  always @(negedge clk50mhz_0) begin
    if (!peripheral_aresetn_0) begin
      mon_beats  = 0;
      mon_pkts   = 0;
      prev_stall = 1'b0;
    end else begin
      chk("beat_count", stat_beat_count, mon_beats);
      chk("pkt_count", stat_pkt_count, mon_pkts);
      if (prev_stall) begin
        chk("hold_valid", rxd.tvalid, 1'b1);
        chk("hold_data", rxd.tdata, prev_data);
        chk("hold_last", rxd.tlast, prev_last);
      end
      if (rxd.tvalid && rxd.tready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          got = sb.pop_front();
          chk("egress_data", rxd.tdata, got.data);
          chk("egress_last", rxd.tlast, got.last);
        end
        mon_beats++;
        if (rxd.tlast) mon_pkts++;
      end
      prev_stall = rxd.tvalid && !rxd.tready;
      prev_data  = rxd.tdata;
      prev_last  = rxd.tlast;
    end
  end

  always @(posedge clk50mhz_0) begin
    if (rand_ready) begin
      #1;
      rxd.tready = 1'($urandom_range(0, 1));
    end
  end

  // All driver tasks start and end at 1ns after a rising edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [1:0] m,
                           input logic [31:0] op);
    int   n;
    exp_t e;
    n = 0;
    txd.tdata  = d;
    txd.tlast  = last;
    txd.tvalid = 1'b1;
    @(negedge clk50mhz_0);
    while (!txd.tready && n < 200) begin
      n++;
      @(negedge clk50mhz_0);
    end
    if (!txd.tready) begin
      chk("accept_timeout", 1'b0, 1'b1);
    end else begin
      e.data = ref_alu(d, m, op);
      e.last = last;
      sb.push_back(e);
    end
    @(posedge clk50mhz_0);
    #1;
    txd.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [1:0] m, input logic [31:0] op);
    cfg_mode    = m;
    cfg_operand = op;
    for (int i = 0; i < n; i++) begin
      send_beat(rand_beat(), i == n - 1, m, op);
      if (i == 0) begin
        cfg_mode    = ~m;
        cfg_operand = ~op;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rxd.tvalid) && n < 400) begin
      @(posedge clk50mhz_0);
      #1;
      n++;
    end
    chk("drain_timeout", (sb.size() == 0 && !rxd.tvalid), 1'b1);
  endtask

  task automatic check_reset_state();
    chk("rst_rxd_tvalid", rxd.tvalid, 1'b0);
    chk("rst_rxd_tlast", rxd.tlast, 1'b0);
    chk("rst_rxd_tdata", rxd.tdata, '0);
    chk("rst_txd_tready", txd.tready, 1'b0);
    chk("rst_pkt_count", stat_pkt_count, 0);
    chk("rst_beat_count", stat_beat_count, 0);
    chk("rst_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk50mhz_0);
    #3;
    peripheral_aresetn_0 = 1'b0;
    #1;
    check_reset_state();
    sb.delete();
    repeat (2) @(posedge clk50mhz_0);
    #2;
    peripheral_aresetn_0 = 1'b1;
    @(posedge clk50mhz_0);
    #1;
    chk("post_reset_tready", txd.tready, 1'b1);
  endtask

  logic [DW-1:0] d;
  logic [DW-1:0] bp[4];
  logic [1:0]    m;
  logic [31:0]   op;
  logic [31:0]   op2;
  int            idx;

  initial begin
    peripheral_aresetn_0 = 1'b0;
    txd.tvalid = 1'b0;
    txd.tdata  = '0;
    txd.tlast  = 1'b0;
    rxd.tready = 1'b1;
    cfg_mode    = 2'd0;
    cfg_operand = '0;
    s_txd.tvalid = 1'b0;
    s_txd.tdata  = '0;
    s_txd.tlast  = 1'b0;
    s_rxd.tready = 1'b1;
    s_mode       = 2'd0;
    s_operand    = '0;

    repeat (3) @(posedge clk50mhz_0);
    #1;
    check_reset_state();
    #1;
    peripheral_aresetn_0 = 1'b1;
    @(posedge clk50mhz_0);
    #1;
    chk("first_tready", txd.tready, 1'b1);

    // Broadcast add, one-cycle latency.
    cfg_mode    = 2'd1;
    cfg_operand = 32'hdeadbeef;
    d = {NL{32'h00000001}};
    send_beat(d, 1'b1, 2'd1, 32'hdeadbeef);
    @(negedge clk50mhz_0);
    chk("lat_tvalid", rxd.tvalid, 1'b1);
    chk("add_const", rxd.tdata, {NL{32'hdeadbef0}});
    chk("add_tlast", rxd.tlast, 1'b1);
    @(posedge clk50mhz_0);
    #1;
    chk("add_pkt_count", stat_pkt_count, 1);
    chk("add_beat_count", stat_beat_count, 1);

    // Lane isolation on wrap.
    cfg_mode    = 2'd1;
    cfg_operand = 32'h2;
    d = rand_beat();
    d[31:0]  = 32'hffffffff;
    d[63:32] = 32'h0;
    send_beat(d, 1'b1, 2'd1, 32'h2);
    @(negedge clk50mhz_0);
    chk("wrap_lane0", rxd.tdata[31:0], 32'h1);
    chk("wrap_lane1", rxd.tdata[63:32], 32'h2);
    @(posedge clk50mhz_0);
    #1;
    cfg_mode    = 2'd2;
    cfg_operand = 32'h1;
    d = rand_beat();
    d[31:0] = 32'h0;
    send_beat(d, 1'b1, 2'd2, 32'h1);
    @(negedge clk50mhz_0);
    chk("borrow_lane0", rxd.tdata[31:0], 32'hffffffff);
    @(posedge clk50mhz_0);
    #1;
    drain();

    // Backpressure: only OR and skid fill while egress is stalled.
    rxd.tready  = 1'b0;
    m  = 2'($urandom_range(0, 3));
    op = $urandom;
    cfg_mode    = m;
    cfg_operand = op;
    for (int i = 0; i < 4; i++) bp[i] = rand_beat();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      txd.tdata  = bp[idx < 4 ? idx : 3];
      txd.tlast  = (idx == 3);
      txd.tvalid = (idx < 4);
      @(negedge clk50mhz_0);
      if (txd.tready && idx < 4) begin
        got.data = ref_alu(bp[idx], m, op);
        got.last = (idx == 3);
        sb.push_back(got);
        idx++;
      end
      @(posedge clk50mhz_0);
      #1;
    end
    txd.tvalid = 1'b0;
    chk("bp_accepted", idx, 2);
    chk("bp_tready_low", txd.tready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    rxd.tready = 1'b1;
    while (idx < 4) begin
      send_beat(bp[idx], idx == 3, m, op);
      idx++;
    end
    drain();

    // Mid-packet config change is ignored until the next packet.
    cfg_mode    = 2'd3;
    cfg_operand = 32'hffffffff;
    send_beat(rand_beat(), 1'b0, 2'd3, 32'hffffffff);
    cfg_mode    = 2'd0;
    cfg_operand = $urandom;
    send_beat(rand_beat(), 1'b0, 2'd3, 32'hffffffff);
    d = rand_beat();
    send_beat(d, 1'b1, 2'd3, 32'hffffffff);
    @(negedge clk50mhz_0);
    chk("inv_last_beat", rxd.tdata, ~d);
    @(posedge clk50mhz_0);
    #1;
    send_beat(rand_beat(), 1'b1, 2'd0, 32'h0);
    drain();

    // Statistics with random egress stalls.
    do_reset();
    rand_ready = 1'b1;
    send_pkt(4, 2'($urandom_range(0, 3)), $urandom);
    send_pkt(1, 2'($urandom_range(0, 3)), $urandom);
    send_pkt(2, 2'($urandom_range(0, 3)), $urandom);
    drain();
    rand_ready = 1'b0;
    @(posedge clk50mhz_0);
    #2;
    rxd.tready = 1'b1;
    @(posedge clk50mhz_0);
    #1;
    chk("stat_pkts", stat_pkt_count, 3);
    chk("stat_beats", stat_beat_count, 7);
    chk("stat_busy", busy, 1'b0);

    // Random traffic.
    rand_ready = 1'b1;
    repeat (25) send_pkt($urandom_range(1, 5), 2'($urandom_range(0, 3)), $urandom);
    drain();
    rand_ready = 1'b0;
    @(posedge clk50mhz_0);
    #2;
    rxd.tready = 1'b1;
    @(posedge clk50mhz_0);
    #1;

    // Reset mid-packet while stalled; next beat is a fresh start-of-packet.
    rxd.tready = 1'b0;
    op  = $urandom;
    op2 = $urandom;
    cfg_mode    = 2'd1;
    cfg_operand = op;
    send_beat(rand_beat(), 1'b0, 2'd1, op);
    cfg_mode    = 2'd3;
    cfg_operand = op2;
    send_beat(rand_beat(), 1'b0, 2'd1, op);
    chk("mid_busy", busy, 1'b1);
    do_reset();
    rxd.tready = 1'b1;
    send_beat(rand_beat(), 1'b1, 2'd3, op2);
    drain();

    // Counter wrap on the 4-bit instance: 17 beats leave 1.
    s_txd.tdata  = {$urandom, $urandom};
    s_txd.tlast  = 1'b1;
    s_txd.tvalid = 1'b1;
    repeat (17) @(posedge clk50mhz_0);
    #1;
    s_txd.tvalid = 1'b0;
    repeat (3) @(posedge clk50mhz_0);
    #1;
    chk("wrap_beat_count", s_beat, 4'd1);
    chk("wrap_pkt_count", s_pkt, 4'd1);
    chk("wrap_busy", s_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
